pipeline_fetch_stage: RTL and testbench
=======================================

# pipeline_fetch_stage

3-wide instruction fetch stage with a private direct-mapped instruction cache, at the front of the out-of-order pipeline. Each cycle it presents up to three sequential instructions to decode and fills cache misses from the tagged, variable-latency unified memory bus (`mem`). A test branch interface redirects the PC.

## Interface
Parameters:
- `XLEN`, 32: address/PC width (global define).
- `ICACHE_LINES`, 32: number of 64-bit cache lines (power of two).

Ports:
- `clock`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem2proc_response`  in  4  0 means the request was not accepted; nonzero is the transaction tag assigned to this cycle's request.
- `mem2proc_data`  in  64  read data returned by memory.
- `mem2proc_tag`  in  4  0 means no reply; nonzero means `mem2proc_data` belongs to that tag.
- `proc2mem_command`  out  2  0 is BUS_NONE, 1 is BUS_LOAD, 2 is BUS_STORE (never driven).
- `proc2mem_addr`  out  XLEN  8-byte-aligned block address; 0 when the command is BUS_NONE.
- `test_take_branch`  in  1  redirect request.
- `test_target_pc`  in  XLEN  redirect target, 4-byte aligned.
- `fetch_packet_out`  out  IF_ID_PACKET[2:0]  each packet has fields {valid, inst[31:0], PC, NPC}.
  - [2] is the oldest slot and holds PC.
  - [1] holds PC+4.
  - [0] holds PC+8.

## Operation
- State:
  - PC register.
  - Cache arrays: data[64] and tag = addr[XLEN-1:3+log2(LINES)] per line, valid bit per line.
  - Cache index = addr[3+log2(LINES)-1:3].
  - Miss tracker: `pending` flag and `pending_tag[3:0]`, `pending_addr`.
- Slot address: slot k uses PC+4k (k=0 is oldest, driven on [2]). Each 64-bit block holds 2 instructions.
  - addr[2]=0 selects bits [31:0].
  - addr[2]=1 selects bits [63:32].
- The three slots span at most two blocks, B=PC[XLEN-1:3] and B+1. The cache has two combinational read ports.
- Slot validity:
  - Slot k is valid iff its block hits, all older slots are valid, and `test_take_branch` is 0.
  - Valid slots are always contiguous from [2].
- Invalid slot: inst = 32'h00000013 (NOP). PC/NPC still show that slot's address and address+4.
- NPC of each slot = its PC+4.
- PC update per clock:
  - `test_take_branch`=1: PC ← `test_target_pc`.
  - Otherwise: PC ← PC + 4×(number of valid slots). Zero valid slots holds the PC.
- Miss request:
  - Condition: not `pending`, and the oldest slot not valid has a missing block (the first missing block among B, B+1 that is needed).
  - Drive BUS_LOAD with that block address.
  - If `mem2proc_response`≠0 at the clock edge: set `pending`, latch the tag and address.
  - If the response is 0: retry the same request next cycle.
- Only one outstanding miss at a time. While `pending`, drive BUS_NONE.
- Fill: when `pending` and `mem2proc_tag`==`pending_tag` (nonzero):
  - Write `mem2proc_data` into line index(`pending_addr`), set the tag and valid bit.
  - Clear `pending`.
  - A new request may be issued in that same cycle.
- A branch does not cancel a pending miss; the fill completes into the cache normally.
- A duplicate request for a block that is pending is never issued.

## Timing
- Reset asserted (low), asynchronously:
  - PC=0, all cache valid bits 0, `pending`=0.
  - All packet valid=0.
  - Command BUS_NONE, addr 0.
- Hit latency: 0 cycles. Packet outputs are combinational from PC and cache contents.
- Fill latency: a filled line is visible starting the cycle after the tag match.
- The request is issued combinationally in the cycle the miss is seen; acceptance is sampled at the same edge.
- Tag match and a new miss in the same cycle: the fill is written at the edge and the request is issued; both are allowed.
- `mem2proc_tag` not matching `pending_tag`, or equal to 0: ignored.
- PC wrap: arithmetic is modulo 2^XLEN.

## Test plan
- Reset then release, with memory preloaded with sequential instructions:
  - First cycle: all valid=0, BUS_LOAD addr 0.
  - After acceptance: BUS_NONE until the tag returns.
  - Next cycle: slots PC 0 and 4 valid; PC 8 is invalid, and BUS_LOAD addr 8 is issued.
- Warm sequential flow, PC=0 with blocks 0..2 cached:
  - Packets PC 0/4/8 valid, NPC 4/8/12.
  - Next cycle: 12/16/20.
- Unaligned start, PC=4, blocks 0 and 8 cached: three valid slots 4/8/12, inst from the upper word of block 0 then both words of block 8.
- `mem2proc_response`=0 for 3 cycles: BUS_LOAD with the same address held 4 cycles; `pending` is set only on the nonzero response.
- `test_take_branch`=1, target 0x40:
  - That cycle: all valid=0.
  - Next cycle: PC=0x40 and a miss request to addr 0x40.
  - A fill pending at the branch still completes.
- Asynchronous reset asserted mid-miss: outputs drop to their reset values immediately; a later reply with the stale tag is ignored.

Source files
------------

// File: rtl/pipeline_fetch_stage.sv
// rtl/pipeline_fetch_stage.sv - 3-wide fetch stage with direct-mapped instruction cache
//
// pipeline_fetch_stage presents up to three sequential instructions per cycle.
// It fills cache misses over the tagged, variable-latency memory bus.
//
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous active-low reset
//   mem2proc_response in   0 = request refused, else tag assigned to this request
//   mem2proc_data     in   64-bit read data for mem2proc_tag
//   mem2proc_tag      in   0 = no reply, else tag of the returning data
//   proc2mem_command  out  BUS_NONE / BUS_LOAD
//   proc2mem_addr     out  8-byte aligned block address (0 when idle)
//   test_take_branch  in   redirect the PC this cycle
//   test_target_pc    in   redirect target
//   fetch_packet_out  out  [2] oldest slot (PC), [1] PC+4, [0] PC+8

package pipeline_fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           inst;
        logic [FETCH_XLEN-1:0] PC;
        logic [FETCH_XLEN-1:0] NPC;
    } IF_ID_PACKET;

endpackage

module pipeline_fetch_stage #(
    parameter int XLEN         = pipeline_fetch_pkg::FETCH_XLEN,
    parameter int ICACHE_LINES = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [3:0]                           mem2proc_response,
    input  logic [63:0]                          mem2proc_data,
    input  logic [3:0]                           mem2proc_tag,
    output logic [1:0]                           proc2mem_command,
    output logic [XLEN-1:0]                      proc2mem_addr,
    input  logic                                 test_take_branch,
    input  logic [XLEN-1:0]                      test_target_pc,
    output pipeline_fetch_pkg::IF_ID_PACKET [2:0] fetch_packet_out
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int BLK_W = XLEN - 3;
    localparam int TAG_W = BLK_W - IDX_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]         pc;
    logic [63:0]             line_data  [ICACHE_LINES];
    logic [TAG_W-1:0]        line_tag   [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] line_valid;

    logic                    pending;
    logic [3:0]              pending_tag;
    logic [BLK_W-1:0]        pending_blk;

    // ------------------------------------------------------------------
    // Two read ports: block B (holds the oldest slot) and block B+1
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] blk0;
    logic [BLK_W-1:0] blk1;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic             hit0;
    logic             hit1;
    logic [63:0]      data0;
    logic [63:0]      data1;

    assign blk0  = pc[XLEN-1:3];
    assign blk1  = blk0 + BLK_W'(1);
    assign idx0  = blk0[IDX_W-1:0];
    assign idx1  = blk1[IDX_W-1:0];
    assign hit0  = line_valid[idx0] && (line_tag[idx0] == blk0[BLK_W-1:IDX_W]);
    assign hit1  = line_valid[idx1] && (line_tag[idx1] == blk1[BLK_W-1:IDX_W]);
    assign data0 = line_data[idx0];
    assign data1 = line_data[idx1];

    // ------------------------------------------------------------------
    // Slot formation and miss selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  slot_pc    [3];
    logic [BLK_W-1:0] slot_blk   [3];
    logic [2:0]       slot_hit;
    logic [2:0]       slot_valid;
    logic [1:0]       n_valid;
    logic             need_req;
    logic [BLK_W-1:0] req_blk;

    always_comb begin
        logic        chain;
        logic        in_b1;
        logic        found;
        logic [63:0] sdata;

        chain    = !test_take_branch;
        found    = 1'b0;
        need_req = 1'b0;
        req_blk  = '0;
        n_valid  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            slot_pc[k]  = pc + XLEN'(4 * k);
            slot_blk[k] = slot_pc[k][XLEN-1:3];
            in_b1       = (slot_blk[k] != blk0);
            slot_hit[k] = in_b1 ? hit1 : hit0;
            sdata       = in_b1 ? data1 : data0;

            chain         = chain & slot_hit[k];
            slot_valid[k] = chain;
            if (chain) begin
                n_valid = n_valid + 2'd1;
            end

            fetch_packet_out[2-k].valid = chain;
            fetch_packet_out[2-k].inst  = !chain ? pipeline_fetch_pkg::NOP_INST :
                                          (slot_pc[k][2] ? sdata[63:32] : sdata[31:0]);
            fetch_packet_out[2-k].PC    = slot_pc[k];
            fetch_packet_out[2-k].NPC   = slot_pc[k] + XLEN'(4);

            // Only the oldest invalid slot may trigger a request; if that slot
            // is invalid merely because of a redirect and its block hits, we
            // leave the bus idle.
            if (!found && !chain) begin
                found = 1'b1;
                if (!slot_hit[k]) begin
                    need_req = 1'b1;
                    req_blk  = slot_blk[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus request / fill
    // ------------------------------------------------------------------
    logic             fill;
    logic             issue;
    logic             accept;
    logic [IDX_W-1:0] fill_idx;

    assign fill     = pending && (mem2proc_tag != 4'd0) && (mem2proc_tag == pending_tag);
    assign fill_idx = pending_blk[IDX_W-1:0];

    // The line being filled only becomes visible next cycle, so a request
    // for that same block during the fill cycle would be a duplicate.
    assign issue  = reset && need_req &&
                    (!pending || (fill && (req_blk != pending_blk)));
    assign accept = issue && (mem2proc_response != 4'd0);

    assign proc2mem_command = issue ? pipeline_fetch_pkg::BUS_LOAD : pipeline_fetch_pkg::BUS_NONE;
    assign proc2mem_addr    = issue ? {req_blk, 3'b000} : '0;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            line_valid  <= '0;
            pending     <= 1'b0;
            pending_tag <= 4'd0;
            pending_blk <= '0;
        end else begin
            if (test_take_branch) begin
                pc <= test_target_pc;
            end else begin
                pc <= pc + XLEN'({n_valid, 2'b00});
            end

            if (fill) begin
                line_valid[fill_idx] <= 1'b1;
            end

            if (accept) begin
                pending     <= 1'b1;
                pending_tag <= mem2proc_response;
                pending_blk <= req_blk;
            end else if (fill) begin
                pending <= 1'b0;
            end
        end
    end

    // Line payloads need no reset: the valid bits gate every use.
    always_ff @(posedge clock) begin
        if (fill) begin
            line_data[fill_idx] <= mem2proc_data;
            line_tag[fill_idx]  <= pending_blk[BLK_W-1:IDX_W];
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// tb/tb_pipeline_fetch_stage.sv - directed self-checking bench for pipeline_fetch_stage
module tb_pipeline_fetch_stage;
    import pipeline_fetch_pkg::*;

    logic                  clock;
    logic                  reset;
    logic [3:0]            resp;
    logic [63:0]           mdata;
    logic [3:0]            mtag;
    logic [1:0]            cmd;
    logic [31:0]           addr;
    logic                  br;
    logic [31:0]           tgt;
    IF_ID_PACKET [2:0]     pk;

    int checks = 0;
    int errors = 0;

    pipeline_fetch_stage #(.XLEN(32), .ICACHE_LINES(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .mem2proc_response (resp),
        .mem2proc_data     (mdata),
        .mem2proc_tag      (mtag),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .test_take_branch  (br),
        .test_target_pc    (tgt),
        .fetch_packet_out  (pk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic logic [63:0] blk(input logic [31:0] a);
        return {ins(a + 32'd4), ins(a)};
    endfunction

    function automatic logic [2:0] vld();
        return {pk[2].valid, pk[1].valid, pk[0].valid};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0; resp = 4'd0; mtag = 4'd0; mdata = 64'd0; br = 1'b0; tgt = 32'd0;
        #1;
        chk("rst_valid", vld(), 3'b000);
        chk("rst_cmd", cmd, 2'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_pc", pk[2].PC, 32'd0);
        chk("rst_nop", pk[2].inst, 32'h13);
        #1 reset = 1'b1;
        #1;
        // cold start, refused three times then accepted with tag 3
        chk("cold_cmd", cmd, 2'd1);
        chk("cold_addr", addr, 32'd0);
        next(); settle();
        chk("retry1_cmd", cmd, 2'd1);
        chk("retry1_addr", addr, 32'd0);
        next(); settle();
        chk("retry2_cmd", cmd, 2'd1);
        chk("retry2_addr", addr, 32'd0);
        next(); resp = 4'd3; settle();
        chk("retry3_cmd", cmd, 2'd1);
        chk("retry3_addr", addr, 32'd0);
        next(); resp = 4'd0; mtag = 4'd5; mdata = 64'hDEAD_BEEF_DEAD_BEEF; settle();
        chk("pend_cmd", cmd, 2'd0);
        chk("pend_valid", vld(), 3'b000);
        next(); mtag = 4'd3; mdata = blk(32'd0); settle();
        chk("wrongtag_still_pending", cmd, 2'd0);
        chk("fill_cycle_valid", vld(), 3'b000);
        next(); mtag = 4'd0; resp = 4'd4; settle();
        chk("after_fill_valid", vld(), 3'b110);
        chk("after_fill_i0", pk[2].inst, 32'hA000_0000);
        chk("after_fill_i1", pk[1].inst, 32'hA000_0004);
        chk("after_fill_nop", pk[0].inst, 32'h13);
        chk("after_fill_pc2", pk[0].PC, 32'd8);
        chk("after_fill_npc2", pk[0].NPC, 32'd12);
        chk("miss8_cmd", cmd, 2'd1);
        chk("miss8_addr", addr, 32'd8);
        next(); resp = 4'd0; mtag = 4'd4; mdata = blk(32'd8); settle();
        chk("pc8", pk[2].PC, 32'd8);
        chk("pc8_cmd", cmd, 2'd0);
        next(); mtag = 4'd0; resp = 4'd6; settle();
        chk("pc8_valid", vld(), 3'b110);
        chk("pc8_i0", pk[2].inst, 32'hA000_0008);
        chk("pc8_i1", pk[1].inst, 32'hA000_000C);
        chk("miss16_cmd", cmd, 2'd1);
        chk("miss16_addr", addr, 32'h10);
        next(); resp = 4'd0; mtag = 4'd6; mdata = blk(32'h10); settle();
        chk("fill16_cmd", cmd, 2'd0);
        // redirect to 0 while the current block hits: no request
        next(); mtag = 4'd0; br = 1'b1; tgt = 32'd0; settle();
        chk("br0_valid", vld(), 3'b000);
        chk("br0_cmd", cmd, 2'd0);
        next(); br = 1'b0; settle();
        chk("warm_valid", vld(), 3'b111);
        chk("warm_pc", {pk[2].PC, pk[1].PC}, {32'd0, 32'd4});
        chk("warm_pc2", pk[0].PC, 32'd8);
        chk("warm_npc", {pk[2].NPC, pk[1].NPC}, {32'd4, 32'd8});
        chk("warm_npc2", pk[0].NPC, 32'd12);
        chk("warm_i2", pk[0].inst, 32'hA000_0008);
        chk("warm_cmd", cmd, 2'd0);
        next(); settle();
        chk("warm2_valid", vld(), 3'b111);
        chk("warm2_pc", {pk[2].PC, pk[1].PC}, {32'd12, 32'd16});
        chk("warm2_pc2", pk[0].PC, 32'd20);
        chk("warm2_i", {pk[2].inst, pk[0].inst}, {32'hA000_000C, 32'hA000_0014});
        next(); br = 1'b1; tgt = 32'd4; settle();
        chk("br4_valid", vld(), 3'b000);
        next(); br = 1'b0; settle();
        chk("unal_valid", vld(), 3'b111);
        chk("unal_i0", pk[2].inst, 32'hA000_0004);
        chk("unal_i1", pk[1].inst, 32'hA000_0008);
        chk("unal_i2", pk[0].inst, 32'hA000_000C);
        // PC=16: block 24 missing, accepted with tag 7
        next(); resp = 4'd7; settle();
        chk("pc16_valid", vld(), 3'b110);
        chk("miss24_addr", addr, 32'h18);
        next(); resp = 4'd0; br = 1'b1; tgt = 32'h40; settle();
        chk("br40_valid", vld(), 3'b000);
        chk("br40_cmd", cmd, 2'd0);
        // fill for 24 returns in the same cycle the new miss at 0x40 is seen
        next(); br = 1'b0; mtag = 4'd7; mdata = blk(32'h18); resp = 4'd8; settle();
        chk("pc40", pk[2].PC, 32'h40);
        chk("pc40_valid", vld(), 3'b000);
        chk("miss40_cmd", cmd, 2'd1);
        chk("miss40_addr", addr, 32'h40);
        next(); mtag = 4'd0; resp = 4'd0; br = 1'b1; tgt = 32'h18; settle();
        chk("br18_cmd", cmd, 2'd0);
        next(); br = 1'b0; settle();
        chk("fill24_valid", vld(), 3'b110);
        chk("fill24_i", {pk[2].inst, pk[1].inst}, {32'hA000_0018, 32'hA000_001C});
        chk("pend40_cmd", cmd, 2'd0);
        // asynchronous reset in the middle of the cycle
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", vld(), 3'b000);
        chk("arst_cmd", cmd, 2'd0);
        chk("arst_addr", addr, 32'd0);
        chk("arst_pc", pk[2].PC, 32'd0);
        #1 reset = 1'b1; mtag = 4'd8; mdata = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk("post_rst_cmd", cmd, 2'd1);
        chk("post_rst_addr", addr, 32'd0);
        next(); mtag = 4'd0; settle();
        chk("stale_ignored_valid", vld(), 3'b000);
        chk("stale_ignored_cmd", cmd, 2'd1);
        chk("stale_ignored_addr", addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
